// File: rtl/thrd_msg_arbiter.sv
// Round-robin arbiter that shares the dispatcher's thread-request channel among
// N_CPU thread controllers, one outstanding transaction at a time, with a timeout.
module thrd_msg_arbiter #(
    parameter int N_CPU   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CPU-1:0]         req,
    input  logic [N_CPU-1:0]         req_op,
    input  logic [N_CPU*ADDR_W-1:0]  req_addr,
    input  logic [N_CPU*DATA_W-1:0]  req_data,
    output logic [N_CPU-1:0]         done,
    output logic [N_CPU-1:0]         err,
    output logic                     busy,
    input  logic                     disp_online,
    output logic                     disp_valid,
    output logic                     disp_op,
    output logic [ADDR_W-1:0]        disp_addr,
    output logic [DATA_W-1:0]        disp_data,
    output logic [$clog2(N_CPU)-1:0] disp_cpu,
    input  logic                     disp_done
);
    localparam int          CPU_W   = $clog2(N_CPU);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t             state_reg;
    logic [CPU_W-1:0]   rr_reg;
    logic [15:0]        cnt_reg;
    logic               mask_reg;
    logic [N_CPU-1:0]   done_reg;
    logic [N_CPU-1:0]   err_reg;
    logic               disp_valid_reg;
    logic               disp_op_reg;
    logic [ADDR_W-1:0]  disp_addr_reg;
    logic [DATA_W-1:0]  disp_data_reg;
    logic [CPU_W-1:0]   disp_cpu_reg;

    logic [ADDR_W-1:0]  addr_arr [N_CPU];
    logic [DATA_W-1:0]  data_arr [N_CPU];
    logic [N_CPU-1:0]   req_elig;
    logic [CPU_W-1:0]   scan_idx;
    logic [CPU_W-1:0]   grant_idx;
    logic               grant_found;

    generate
        for (genvar gi = 0; gi < N_CPU; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from furthest to nearest so the nearest requester after rr wins;
    // the CPU just served is masked for the first IDLE cycle after its ACK.
    always_comb begin
        req_elig = req;
        if (mask_reg) begin
            req_elig[rr_reg] = 1'b0;
        end
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = N_CPU; k >= 1; k--) begin
            scan_idx = CPU_W'((int'(rr_reg) + k) % N_CPU);
            if (req_elig[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rr_reg         <= CPU_W'(N_CPU - 1);
            cnt_reg        <= '0;
            mask_reg       <= 1'b0;
            done_reg       <= '0;
            err_reg        <= '0;
            disp_valid_reg <= 1'b0;
            disp_op_reg    <= 1'b0;
            disp_addr_reg  <= '0;
            disp_data_reg  <= '0;
            disp_cpu_reg   <= '0;
        end else begin
            disp_valid_reg <= 1'b0;
            done_reg       <= '0;
            err_reg        <= '0;
            case (state_reg)
                IDLE: begin
                    mask_reg <= 1'b0;
                    if (disp_online && grant_found) begin
                        disp_op_reg    <= req_op[grant_idx];
                        disp_addr_reg  <= addr_arr[grant_idx];
                        disp_data_reg  <= data_arr[grant_idx];
                        disp_cpu_reg   <= grant_idx;
                        rr_reg         <= grant_idx;
                        disp_valid_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                    if (disp_done) begin
                        done_reg[disp_cpu_reg] <= 1'b1;
                        state_reg              <= ACK;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // A done arriving in the timeout cycle still counts as success.
                    if (disp_done) begin
                        done_reg[disp_cpu_reg] <= 1'b1;
                        state_reg              <= ACK;
                    end else if (cnt_reg == TO_LAST) begin
                        done_reg[disp_cpu_reg] <= 1'b1;
                        err_reg[disp_cpu_reg]  <= 1'b1;
                        state_reg              <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ACK: begin
                    mask_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done       = done_reg;
    assign err        = err_reg;
    assign busy       = (state_reg != IDLE);
    assign disp_valid = disp_valid_reg;
    assign disp_op    = disp_op_reg;
    assign disp_addr  = disp_addr_reg;
    assign disp_data  = disp_data_reg;
    assign disp_cpu   = disp_cpu_reg;
endmodule
